// File: rtl/rtc_bus_sequencer_if.sv
// Bus bundle for rtc_bus_sequencer.
//   Request side : start, mode, ch_mask, addr_table, wr_data, auto_en
//   AD buffer    : ad_in (from buffer), ad_out / ad_oe (to buffer)
//   RTC strobes  : a_d, cs, rd, wr (active low except a_d)
//   Status       : busy, done, rd_data, rd_valid
// slave  = the sequencer; master = the controller / environment driving it.
interface rtc_bus_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REGS = 9
);
  logic                       start;
  logic [1:0]                 mode;
  logic [N_REGS-1:0]          ch_mask;
  logic [N_REGS*DATA_W-1:0]   addr_table;
  logic [N_REGS*DATA_W-1:0]   wr_data;
  logic                       auto_en;
  logic [DATA_W-1:0]          ad_in;
  logic [DATA_W-1:0]          ad_out;
  logic                       ad_oe;
  logic                       a_d;
  logic                       cs;
  logic                       rd;
  logic                       wr;
  logic                       busy;
  logic                       done;
  logic [N_REGS*DATA_W-1:0]   rd_data;
  logic [N_REGS-1:0]          rd_valid;

  modport master (
    output start, mode, ch_mask, addr_table, wr_data, auto_en, ad_in,
    input  ad_out, ad_oe, a_d, cs, rd, wr, busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, mode, ch_mask, addr_table, wr_data, auto_en, ad_in,
    output ad_out, ad_oe, a_d, cs, rd, wr, busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Transaction engine for the RTC multiplexed address/data bus.
// Runs masked read / write / command-only bursts over a table of N_REGS
// register addresses, plus periodic auto-refresh read bursts.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : rtc_bus_sequencer_if.slave (request inputs, AD buffer,
//                RTC strobes, busy/done status, captured read data)
// All bus-facing outputs are registered from the next-state values.
module rtc_bus_sequencer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned N_REGS         = 9,
  parameter int unsigned T_PULSE        = 4,
  parameter int unsigned T_GAP          = 2,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned TW      = $clog2(REFRESH_CYCLES);

  localparam logic [CW-1:0] P_LAST = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] G_LAST = CW'(T_GAP - 1);
  localparam logic [TW-1:0] T_LAST = TW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D, SCAN, DONE} state_t;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_CMD = 2'b10} op_t;

  state_t                     state, state_nx;
  logic [CW-1:0]              cnt, cnt_nx;
  logic [IW-1:0]              idx, idx_nx;
  logic [N_REGS-1:0]          rem, rem_nx;
  op_t                        op, op_nx;
  logic [N_REGS*DATA_W-1:0]   addr_q, addr_nx;
  logic [N_REGS*DATA_W-1:0]   wdata_q, wdata_nx;

  logic                       launch, refresh_go, capture, scan;
  logic [N_REGS-1:0]          scan_src;
  logic [IW-1:0]              first_idx;

  logic [TW-1:0]              timer;
  logic                       pending;

  logic                       cs_nx, rd_nx, wr_nx, a_d_nx, oe_nx, busy_nx, done_nx;
  logic [DATA_W-1:0]          out_nx;
  logic                       cs_q, rd_q, wr_q, a_d_q, oe_q, busy_q, done_q;
  logic [DATA_W-1:0]          out_q;
  logic [N_REGS*DATA_W-1:0]   rd_data_q;
  logic [N_REGS-1:0]          rd_valid_q;

  // Channels still to visit: the live mask when launching, otherwise what
  // remains of the snapshot. The current channel's bit is dropped on entry.
  assign scan_src = (state == IDLE) ? bus.ch_mask : rem;

  always_comb begin
    first_idx = '0;
    for (int unsigned i = N_REGS; i > 0; i--) begin
      if (scan_src[i-1]) first_idx = IW'(i - 1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      rem     <= '0;
      op      <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      rem     <= rem_nx;
      op      <= op_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Next-state logic. SCAN is never occupied: it is resolved in the same
  // cycle as the transition that requests it, so it takes zero cycles.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    rem_nx     = rem;
    op_nx      = op;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    launch     = 1'b0;
    refresh_go = 1'b0;
    capture    = 1'b0;
    scan       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          launch   = 1'b1;
          scan     = 1'b1;
          addr_nx  = bus.addr_table;
          wdata_nx = bus.wr_data;
          unique case (bus.mode)
            2'b00:   op_nx = OP_READ;
            2'b01:   op_nx = OP_WRITE;
            default: op_nx = OP_CMD;
          endcase
        end else if (pending) begin
          launch     = 1'b1;
          refresh_go = 1'b1;
          scan       = 1'b1;
          addr_nx    = bus.addr_table;
          op_nx      = OP_READ;
        end
      end
      ADDR, DATA: begin
        if (cnt == P_LAST) begin
          cnt_nx   = '0;
          state_nx = (state == ADDR) ? GAP_A : GAP_D;
          capture  = (state == DATA) && (op == OP_READ);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      GAP_A, GAP_D: begin
        if (cnt == G_LAST) begin
          cnt_nx = '0;
          if (state == GAP_A && op != OP_CMD) state_nx = DATA;
          else                                scan     = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SCAN:    scan     = 1'b1;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (scan) begin
      if (|scan_src) begin
        state_nx = ADDR;
        cnt_nx   = '0;
        idx_nx   = first_idx;
        rem_nx   = scan_src & ~(N_REGS'(1) << first_idx);
      end else begin
        state_nx = DONE;
        rem_nx   = '0;
      end
    end
  end

  // Output logic, evaluated on next-state values so the pins are registered
  always_comb begin
    cs_nx   = 1'b1;
    rd_nx   = 1'b1;
    wr_nx   = 1'b1;
    a_d_nx  = 1'b1;
    oe_nx   = 1'b0;
    out_nx  = '0;
    busy_nx = 1'b0;
    done_nx = (state_nx == DONE);
    unique case (state_nx)
      ADDR, GAP_A: begin
        busy_nx = 1'b1;
        a_d_nx  = 1'b0;
        oe_nx   = 1'b1;
        out_nx  = addr_nx[idx_nx*DATA_W +: DATA_W];
        if (state_nx == ADDR) begin
          cs_nx = 1'b0;
          wr_nx = 1'b0;
        end
      end
      DATA, GAP_D: begin
        busy_nx = 1'b1;
        if (op_nx == OP_WRITE) begin
          oe_nx  = 1'b1;
          out_nx = wdata_nx[idx_nx*DATA_W +: DATA_W];
        end
        if (state_nx == DATA) begin
          cs_nx = 1'b0;
          if (op_nx == OP_WRITE) wr_nx = 1'b0;
          else                   rd_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      a_d_q      <= 1'b1;
      oe_q       <= 1'b0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      cs_q   <= cs_nx;
      rd_q   <= rd_nx;
      wr_q   <= wr_nx;
      a_d_q  <= a_d_nx;
      oe_q   <= oe_nx;
      out_q  <= out_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (launch && op_nx == OP_READ) rd_valid_q <= '0;
      if (capture) begin
        rd_data_q[idx*DATA_W +: DATA_W] <= bus.ad_in;
        rd_valid_q[idx]                 <= 1'b1;
      end
    end
  end

  // Refresh timer. A wrap outranks a same-cycle refresh launch so the
  // request is never lost; repeated wraps collapse into one pending flag.
  always_ff @(posedge clk) begin
    if (reset || !bus.auto_en) begin
      timer   <= '0;
      pending <= 1'b0;
    end else if (timer == T_LAST) begin
      timer   <= '0;
      pending <= 1'b1;
    end else begin
      timer <= timer + TW'(1);
      if (refresh_go) pending <= 1'b0;
    end
  end

  assign bus.cs       = cs_q;
  assign bus.rd       = rd_q;
  assign bus.wr       = wr_q;
  assign bus.a_d      = a_d_q;
  assign bus.ad_oe    = oe_q;
  assign bus.ad_out   = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
